// File: rtl/load_use_stall_controller.sv
// load_use_stall_controller: holds an EX consumer of an in-flight load until the load reaches WB,
// freezes the memory stages on data-memory wait and counts stall cycles (saturating).
module load_use_stall_controller #(
   parameter int   REG_ADD_WIDTH = 5,
   parameter int   COUNT_WIDTH   = 32,
   parameter logic HIGH          = 1'b1,
   parameter logic LOW           = 1'b0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     EX_VALID,
   input  logic [REG_ADD_WIDTH-1:0] RS1_ADDRESS_EXECUTION,
   input  logic                     RS1_USED_EXECUTION,
   input  logic [REG_ADD_WIDTH-1:0] RS2_ADDRESS_EXECUTION,
   input  logic                     RS2_USED_EXECUTION,
   input  logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM1,
   input  logic                     LOAD_DM1,
   input  logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM2,
   input  logic                     LOAD_DM2,
   input  logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM3,
   input  logic                     LOAD_DM3,
   input  logic                     DM_READY,
   input  logic                     CLEAR_COUNT,
   output logic                     STALL_FETCH_STAGE,
   output logic                     STALL_DECODE_STAGE,
   output logic                     STALL_EXECUTION_STAGE,
   output logic                     BUBBLE_DM1,
   output logic                     FREEZE_MEMORY_STAGES,
   output logic [COUNT_WIDTH-1:0]   STALL_CYCLE_COUNT
);
   typedef enum logic {IDLE, LOAD_STALL} state_t;
   state_t                 state_q, state_d;
   logic [1:0]             cnt_q, cnt_d, need;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   m1, m2, m3, hazard, busy, stall;

   // x0 is never a real producer, so a zero rd can not match
   assign m1 = LOAD_DM1 && RD_ADDRESS_DM1 != '0 &&
               ((RS1_USED_EXECUTION && RS1_ADDRESS_EXECUTION == RD_ADDRESS_DM1) ||
                (RS2_USED_EXECUTION && RS2_ADDRESS_EXECUTION == RD_ADDRESS_DM1));
   assign m2 = LOAD_DM2 && RD_ADDRESS_DM2 != '0 &&
               ((RS1_USED_EXECUTION && RS1_ADDRESS_EXECUTION == RD_ADDRESS_DM2) ||
                (RS2_USED_EXECUTION && RS2_ADDRESS_EXECUTION == RD_ADDRESS_DM2));
   assign m3 = LOAD_DM3 && RD_ADDRESS_DM3 != '0 &&
               ((RS1_USED_EXECUTION && RS1_ADDRESS_EXECUTION == RD_ADDRESS_DM3) ||
                (RS2_USED_EXECUTION && RS2_ADDRESS_EXECUTION == RD_ADDRESS_DM3));
   assign need   = m1 ? 2'd3 : m2 ? 2'd2 : m3 ? 2'd1 : 2'd0;
   assign hazard = EX_VALID && need != 2'd0;
   assign busy   = state_q == LOAD_STALL || hazard;
   assign stall  = busy || !DM_READY;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

   // the remaining-stall count only advances on cycles the memory stages move
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (DM_READY && state_q == IDLE && hazard && need != 2'd1) begin
         state_d = LOAD_STALL;
         cnt_d   = need - 2'd1;
      end else if (DM_READY && state_q == LOAD_STALL) begin
         state_d = cnt_q == 2'd1 ? IDLE : LOAD_STALL;
         cnt_d   = cnt_q - 2'd1;
      end
      count_d = CLEAR_COUNT ? '0 :
                (stall && count_q != '1) ? count_q + COUNT_WIDTH'(1) : count_q;
   end

   // reset gates every output so they drop the instant RST rises
   always_comb begin
      STALL_FETCH_STAGE     = (!RST && stall) ? HIGH : LOW;
      STALL_DECODE_STAGE    = (!RST && stall) ? HIGH : LOW;
      STALL_EXECUTION_STAGE = (!RST && stall) ? HIGH : LOW;
      BUBBLE_DM1            = (!RST && DM_READY && busy) ? HIGH : LOW;
      FREEZE_MEMORY_STAGES  = (!RST && !DM_READY) ? HIGH : LOW;
      STALL_CYCLE_COUNT     = count_q;
   end
endmodule

// File: tb/tb_load_use_stall_controller.sv
// tb_load_use_stall_controller: directed scoreboard bench for load_use_stall_controller (4-bit counter).
module tb_load_use_stall_controller;
   localparam int W = 4;
   logic         CLK = 1'b0, RST;
   logic         EX_VALID, RS1_USED_EXECUTION, RS2_USED_EXECUTION;
   logic [4:0]   RS1_ADDRESS_EXECUTION, RS2_ADDRESS_EXECUTION;
   logic [4:0]   RD_ADDRESS_DM1, RD_ADDRESS_DM2, RD_ADDRESS_DM3;
   logic         LOAD_DM1, LOAD_DM2, LOAD_DM3, DM_READY, CLEAR_COUNT;
   logic         STALL_FETCH_STAGE, STALL_DECODE_STAGE, STALL_EXECUTION_STAGE;
   logic         BUBBLE_DM1, FREEZE_MEMORY_STAGES;
   logic [W-1:0] STALL_CYCLE_COUNT;

   always #5 CLK = ~CLK;

   load_use_stall_controller #(.COUNT_WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .EX_VALID(EX_VALID),
      .RS1_ADDRESS_EXECUTION(RS1_ADDRESS_EXECUTION), .RS1_USED_EXECUTION(RS1_USED_EXECUTION),
      .RS2_ADDRESS_EXECUTION(RS2_ADDRESS_EXECUTION), .RS2_USED_EXECUTION(RS2_USED_EXECUTION),
      .RD_ADDRESS_DM1(RD_ADDRESS_DM1), .LOAD_DM1(LOAD_DM1),
      .RD_ADDRESS_DM2(RD_ADDRESS_DM2), .LOAD_DM2(LOAD_DM2),
      .RD_ADDRESS_DM3(RD_ADDRESS_DM3), .LOAD_DM3(LOAD_DM3),
      .DM_READY(DM_READY), .CLEAR_COUNT(CLEAR_COUNT),
      .STALL_FETCH_STAGE(STALL_FETCH_STAGE), .STALL_DECODE_STAGE(STALL_DECODE_STAGE),
      .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE), .BUBBLE_DM1(BUBBLE_DM1),
      .FREEZE_MEMORY_STAGES(FREEZE_MEMORY_STAGES), .STALL_CYCLE_COUNT(STALL_CYCLE_COUNT)
   );

   typedef struct {
      string        tag;
      logic [4:0]   ctl;
      logic [W-1:0] cnt;
   } exp_t;
   exp_t         sb[$];
   int           checks = 0, passed = 0, failed = 0;
   logic [W-1:0] exp_cnt;
   logic [4:0]   obs;

   assign obs = {STALL_FETCH_STAGE, STALL_DECODE_STAGE, STALL_EXECUTION_STAGE,
                 BUBBLE_DM1, FREEZE_MEMORY_STAGES};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, "_ctl"}, 32'(obs), 32'(e.ctl));
         chk({e.tag, "_cnt"}, 32'(STALL_CYCLE_COUNT), 32'(e.cnt));
      end
   end

   // one clock: queue the expected outputs for this cycle, then apply the counter model at the edge
   task automatic cyc(input string tag, input logic st, input logic bub, input logic frz);
      exp_t e;
      e.tag = tag;
      e.ctl = {st, st, st, bub, frz};
      e.cnt = exp_cnt;
      sb.push_back(e);
      @(posedge CLK);
      exp_cnt = CLEAR_COUNT ? '0 : (st && exp_cnt != '1) ? exp_cnt + 1'b1 : exp_cnt;
      #1;
   endtask

   task automatic src(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
      RS1_ADDRESS_EXECUTION = r1;
      RS1_USED_EXECUTION    = u1;
      RS2_ADDRESS_EXECUTION = r2;
      RS2_USED_EXECUTION    = u2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; EX_VALID = 1'b1; DM_READY = 1'b0; CLEAR_COUNT = 1'b0;
      src(5'd0, 1'b0, 5'd0, 1'b0);
      LOAD_DM1 = 1'b0; LOAD_DM2 = 1'b0; LOAD_DM3 = 1'b0;
      RD_ADDRESS_DM1 = 5'd0; RD_ADDRESS_DM2 = 5'd0; RD_ADDRESS_DM3 = 5'd0;
      exp_cnt = '0;
      #7;
      chk("reset_ctl", 32'(obs), 32'd0);
      chk("reset_cnt", 32'(STALL_CYCLE_COUNT), 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0; DM_READY = 1'b1;
      // load x5 in DM1, consumer rs1: three stall cycles, then proceed
      src(5'd5, 1'b1, 5'd0, 1'b0);
      LOAD_DM1 = 1'b1; RD_ADDRESS_DM1 = 5'd5;
      cyc("dm1_c1", 1, 1, 0);
      LOAD_DM1 = 1'b0; LOAD_DM2 = 1'b1; RD_ADDRESS_DM2 = 5'd5;
      cyc("dm1_c2", 1, 1, 0);
      LOAD_DM2 = 1'b0; LOAD_DM3 = 1'b1; RD_ADDRESS_DM3 = 5'd5;
      cyc("dm1_c3", 1, 1, 0);
      LOAD_DM3 = 1'b0;
      cyc("dm1_c4", 0, 0, 0);
      CLEAR_COUNT = 1'b1;
      cyc("clr1", 0, 0, 0);
      CLEAR_COUNT = 1'b0;
      // load x7 in DM3 via rs2: single stall, FSM stays idle
      src(5'd0, 1'b0, 5'd7, 1'b1);
      LOAD_DM3 = 1'b1; RD_ADDRESS_DM3 = 5'd7;
      cyc("dm3_c1", 1, 1, 0);
      LOAD_DM3 = 1'b0;
      cyc("dm3_c2", 0, 0, 0);
      // loads in DM2 and DM3 against both operands: two stalls
      src(5'd9, 1'b1, 5'd4, 1'b1);
      LOAD_DM2 = 1'b1; RD_ADDRESS_DM2 = 5'd4; LOAD_DM3 = 1'b1; RD_ADDRESS_DM3 = 5'd9;
      cyc("dm23_c1", 1, 1, 0);
      LOAD_DM2 = 1'b0; RD_ADDRESS_DM3 = 5'd4;
      cyc("dm23_c2", 1, 1, 0);
      LOAD_DM3 = 1'b0;
      cyc("dm23_c3", 0, 0, 0);
      // non-hazards: x0, unused operands, invalid EX
      src(5'd0, 1'b1, 5'd0, 1'b0);
      LOAD_DM1 = 1'b1; RD_ADDRESS_DM1 = 5'd0;
      cyc("x0", 0, 0, 0);
      src(5'd5, 1'b0, 5'd5, 1'b0);
      RD_ADDRESS_DM1 = 5'd5;
      cyc("unused", 0, 0, 0);
      src(5'd5, 1'b1, 5'd0, 1'b0);
      EX_VALID = 1'b0;
      cyc("ex_invalid", 0, 0, 0);
      EX_VALID = 1'b1; LOAD_DM1 = 1'b0; CLEAR_COUNT = 1'b1;
      cyc("clr2", 0, 0, 0);
      CLEAR_COUNT = 1'b0;
      // DM1 hazard with a 4-cycle memory wait on the second stall cycle
      LOAD_DM1 = 1'b1; RD_ADDRESS_DM1 = 5'd5;
      cyc("frz_c1", 1, 1, 0);
      LOAD_DM1 = 1'b0; LOAD_DM2 = 1'b1; RD_ADDRESS_DM2 = 5'd5; DM_READY = 1'b0;
      for (int i = 0; i < 4; i++) cyc("frz_hold", 1, 0, 1);
      DM_READY = 1'b1;
      cyc("frz_c2", 1, 1, 0);
      LOAD_DM2 = 1'b0; LOAD_DM3 = 1'b1; RD_ADDRESS_DM3 = 5'd5;
      cyc("frz_c3", 1, 1, 0);
      LOAD_DM3 = 1'b0;
      cyc("frz_done", 0, 0, 0);
      // memory wait with no hazard, then an idle hazard waiting on memory
      DM_READY = 1'b0;
      cyc("frz_nohaz", 1, 0, 1);
      LOAD_DM1 = 1'b1;
      cyc("idle_wait", 1, 0, 1);
      DM_READY = 1'b1;
      cyc("idle_go", 1, 1, 0);
      // asynchronous reset in the middle of LOAD_STALL
      LOAD_DM1 = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      chk("rst_mid_ctl", 32'(obs), 32'd0);
      chk("rst_mid_cnt", 32'(STALL_CYCLE_COUNT), 32'd0);
      DM_READY = 1'b0;
      #1;
      chk("rst_mid_frz", 32'(obs), 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0; DM_READY = 1'b1; exp_cnt = '0;
      cyc("post_rst", 0, 0, 0);
      // saturation and clear while stalling
      DM_READY = 1'b0;
      for (int i = 0; i < 15; i++) cyc("sat_fill", 1, 0, 1);
      for (int i = 0; i < 2; i++) cyc("sat_hold", 1, 0, 1);
      CLEAR_COUNT = 1'b1;
      cyc("sat_clr", 1, 0, 1);
      CLEAR_COUNT = 1'b0;
      cyc("sat_after", 1, 0, 1);
      DM_READY = 1'b1;
      cyc("final", 0, 0, 0);
      @(negedge CLK);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
